// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - BTB plus 2-bit counter branch predictor; BP_GHR_EN selects gshare PHT indexing
module branch_predictor #(
   parameter int INDEX_BITS = 4,
   parameter int GHR_BITS   = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [31:0]           pc_if,
   output logic                  pred_taken_if,
   output logic [31:0]           pred_target_if,
   output logic [INDEX_BITS-1:0] pht_idx_if,
   input  logic                  upd_valid,
   input  logic [31:0]           pc_ex,
   input  logic                  taken_ex,
   input  logic [31:0]           target_ex,
   input  logic                  pred_taken_ex,
   input  logic [31:0]           pred_target_ex,
   input  logic [INDEX_BITS-1:0] pht_idx_ex,
   output logic                  mispredict,
   output logic [31:0]           redirect_pc
);

   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = 30 - INDEX_BITS;

   logic                btb_valid  [ENTRIES];
   logic [TAG_BITS-1:0] btb_tag    [ENTRIES];
   logic [31:0]         btb_target [ENTRIES];
   logic [1:0]          pht        [ENTRIES];

   logic [INDEX_BITS-1:0] btb_idx_if;
   logic [INDEX_BITS-1:0] btb_idx_ex;
   logic [TAG_BITS-1:0]   tag_if;
   logic [TAG_BITS-1:0]   tag_ex;
   logic                  hit_if;
   logic [31:0]           pc_if_plus4;
   logic [31:0]           pc_ex_plus4;
   logic                  unused_pc_bits;

   assign btb_idx_if  = pc_if[INDEX_BITS+1:2];
   assign btb_idx_ex  = pc_ex[INDEX_BITS+1:2];
   assign tag_if      = pc_if[31:INDEX_BITS+2];
   assign tag_ex      = pc_ex[31:INDEX_BITS+2];
   assign pc_if_plus4 = pc_if + 32'd4;
   assign pc_ex_plus4 = pc_ex + 32'd4;
   assign unused_pc_bits = ^{pc_if[1:0], pc_ex[1:0]};

`ifdef BP_GHR_EN
   logic [GHR_BITS-1:0] ghr;

   // gshare: fold global history into the counter index only; the BTB stays PC-indexed
   assign pht_idx_if = btb_idx_if ^ INDEX_BITS'(ghr);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ghr <= '0;
      end else if (upd_valid) begin
         ghr <= {ghr[GHR_BITS-2:0], taken_ex};
      end
   end
`else
   localparam int unused_ghr_bits = GHR_BITS;

   assign pht_idx_if = btb_idx_if;
`endif

   assign hit_if         = btb_valid[btb_idx_if] && (btb_tag[btb_idx_if] == tag_if);
   assign pred_taken_if  = hit_if && pht[pht_idx_if][1];
   assign pred_target_if = pred_taken_if ? btb_target[btb_idx_if] : pc_if_plus4;

   assign mispredict  = upd_valid &&
                        ((taken_ex != pred_taken_ex) || (taken_ex && (target_ex != pred_target_ex)));
   assign redirect_pc = taken_ex ? target_ex : pc_ex_plus4;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_valid[i] <= 1'b0;
            pht[i]       <= 2'b01;
         end
      end else if (upd_valid) begin
         if (taken_ex) begin
            btb_valid[btb_idx_ex] <= 1'b1;
            if (pht[pht_idx_ex] != 2'b11) begin
               pht[pht_idx_ex] <= pht[pht_idx_ex] + 2'd1;
            end
         end else if (pht[pht_idx_ex] != 2'b00) begin
            pht[pht_idx_ex] <= pht[pht_idx_ex] - 2'd1;
         end
      end
   end

   // Tag/target need no reset: they are ignored until the valid bit is set
   always_ff @(posedge clk) begin
      if (reset_n && upd_valid && taken_ex) begin
         btb_tag[btb_idx_ex]    <= tag_ex;
         btb_target[btb_idx_ex] <= target_ex;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

   logic        clk;
   logic        reset_n;
   logic [31:0] pc_if;
   logic        pred_taken_if;
   logic [31:0] pred_target_if;
   logic [3:0]  pht_idx_if;
   logic        upd_valid;
   logic [31:0] pc_ex;
   logic        taken_ex;
   logic [31:0] target_ex;
   logic        pred_taken_ex;
   logic [31:0] pred_target_ex;
   logic [3:0]  pht_idx_ex;
   logic        mispredict;
   logic [31:0] redirect_pc;

   int total;
   int passed;

   branch_predictor #(.INDEX_BITS(4), .GHR_BITS(4)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .pc_if          (pc_if),
      .pred_taken_if  (pred_taken_if),
      .pred_target_if (pred_target_if),
      .pht_idx_if     (pht_idx_if),
      .upd_valid      (upd_valid),
      .pc_ex          (pc_ex),
      .taken_ex       (taken_ex),
      .target_ex      (target_ex),
      .pred_taken_ex  (pred_taken_ex),
      .pred_target_ex (pred_target_ex),
      .pht_idx_ex     (pht_idx_ex),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
   endtask

   task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
      upd_valid      = 1'b1;
      pc_ex          = pc;
      taken_ex       = tk;
      target_ex      = tgt;
      pred_taken_ex  = ptk;
      pred_target_ex = ptgt;
      pht_idx_ex     = pc[5:2];
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
      upd_valid = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_tk,
                         input logic [31:0] exp_tgt);
      pc_if = pc;
      #1;
      check({tag, "_taken"}, {31'd0, pred_taken_if}, {31'd0, exp_tk});
      check({tag, "_target"}, pred_target_if, exp_tgt);
   endtask

   initial begin
      total = 0;
      passed = 0;
      reset_n = 1'b0;
      pc_if = 32'h100;
      upd_valid = 1'b0;
      pc_ex = '0;
      taken_ex = 1'b0;
      target_ex = '0;
      pred_taken_ex = 1'b0;
      pred_target_ex = '0;
      pht_idx_ex = '0;
      #2;
      lookup("rst_0x100", 32'h100, 1'b0, 32'h104);
      check("rst_mispredict", {31'd0, mispredict}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;

      lookup("post_rst_0x100", 32'h100, 1'b0, 32'h104);
      check("pht_idx_0x100", {28'd0, pht_idx_if}, 32'd0);
      lookup("pht_idx_probe", 32'h1234, 1'b0, 32'h1238);
      check("pht_idx_0x1234", {28'd0, pht_idx_if}, 32'hD);

      // first taken update: allocate, counter 01 -> 10
      pc_if = 32'h100;
      set_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
      check("alloc_mispredict", {31'd0, mispredict}, 32'd1);
      check("alloc_redirect", redirect_pc, 32'h200);
      check("no_bypass_taken", {31'd0, pred_taken_if}, 32'd0);
      tick();
      lookup("after_alloc", 32'h100, 1'b1, 32'h200);

      // four more taken: counter saturates at 11
      for (int i = 0; i < 4; i++) begin
         set_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
         check("taken_correct_mispredict", {31'd0, mispredict}, 32'd0);
         tick();
      end
      set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
      check("nt_mispredict", {31'd0, mispredict}, 32'd1);
      check("nt_redirect", redirect_pc, 32'h104);
      tick();
      lookup("after_nt1", 32'h100, 1'b1, 32'h200);
      set_upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
      tick();
      lookup("after_nt2", 32'h100, 1'b0, 32'h104);

      // counter 01: correct-taken then target mismatch
      set_upd(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
      check("match_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
      set_upd(32'h100, 1'b1, 32'h204, 1'b1, 32'h200);
      check("tgt_mispredict", {31'd0, mispredict}, 32'd1);
      check("tgt_redirect", redirect_pc, 32'h204);
      tick();
      lookup("after_retarget", 32'h100, 1'b1, 32'h204);

      // alias at 0x140 replaces the 0x100 entry
      set_upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
      tick();
      lookup("alias_old_miss", 32'h100, 1'b0, 32'h104);
      lookup("alias_new_hit", 32'h140, 1'b1, 32'h300);

      // not-taken does not allocate; counter saturates at 00
      set_upd(32'h108, 1'b0, 32'h400, 1'b0, 32'h10C);
      check("nt_correct_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
      set_upd(32'h108, 1'b0, 32'h400, 1'b0, 32'h10C);
      tick();
      set_upd(32'h108, 1'b1, 32'h400, 1'b0, 32'h10C);
      tick();
      lookup("sat00_first_taken", 32'h108, 1'b0, 32'h10C);
      set_upd(32'h108, 1'b1, 32'h400, 1'b0, 32'h10C);
      tick();
      lookup("sat00_second_taken", 32'h108, 1'b1, 32'h400);

      // idle cycle with junk update fields changes nothing
      upd_valid = 1'b0;
      pc_ex = 32'h140;
      taken_ex = 1'b1;
      target_ex = 32'h999;
      pred_taken_ex = 1'b0;
      pht_idx_ex = 4'h0;
      #1;
      check("idle_mispredict", {31'd0, mispredict}, 32'd0);
      tick();
      lookup("idle_no_change", 32'h140, 1'b1, 32'h300);

      // 32-bit wrap
      lookup("wrap_lookup", 32'hFFFF_FFFC, 1'b0, 32'h0);
      set_upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h1000);
      check("wrap_mispredict", {31'd0, mispredict}, 32'd1);
      check("wrap_redirect", redirect_pc, 32'h0);
      tick();

      // asynchronous reset between edges, with a coincident update discarded
      pc_if = 32'h140;
      #1;
      check("pre_async_taken", {31'd0, pred_taken_if}, 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check("async_rst_taken", {31'd0, pred_taken_if}, 32'd0);
      check("async_rst_target", pred_target_if, 32'h144);
      set_upd(32'h140, 1'b1, 32'h500, 1'b1, 32'h300);
      tick();
      reset_n = 1'b1;
      #1;
      lookup("post_async_miss", 32'h140, 1'b0, 32'h144);
      set_upd(32'h140, 1'b1, 32'h300, 1'b0, 32'h144);
      tick();
      lookup("post_async_wnt", 32'h140, 1'b1, 32'h300);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter INDEX_BITS, default 4, giving the log2 number of BTB/PHT entries (16).
REQ-002 The block SHALL have parameter GHR_BITS, default 4, giving the global history width; it is used only when BP_GHR_EN is defined.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, the reset; it is asynchronous and active-low.
REQ-005 The block SHALL have port pc_if, input, 32, the fetch PC to predict.
REQ-006 The block SHALL have port pred_taken_if, output, 1, which predicts the branch at pc_if as taken.
REQ-007 The block SHALL have port pred_target_if, output, 32, giving the predicted target; it is valid when pred_taken_if=1, else pc_if+4.
REQ-008 The block SHALL have port pht_idx_if, output, INDEX_BITS, giving the PHT index used for this prediction; the pipeline carries it to EX.
REQ-009 The block SHALL have port upd_valid, input, 1, which is high for one cycle per resolved conditional branch in EX.
REQ-010 The block SHALL have port pc_ex, input, 32, giving the PC of the resolving branch.
REQ-011 The block SHALL have port taken_ex, input, 1, giving the actual outcome (branch-logic pc_sel_ex).
REQ-012 The block SHALL have port target_ex, input, 32, giving the actual branch target.
REQ-013 The block SHALL have port pred_taken_ex, input, 1, carrying the prediction made for this branch at IF.
REQ-014 The block SHALL have port pred_target_ex, input, 32, carrying the predicted target for this branch.
REQ-015 The block SHALL have port pht_idx_ex, input, INDEX_BITS, carrying the pht_idx_if value for this branch.
REQ-016 The block SHALL have port mispredict, output, 1, which requests a flush and redirect.
REQ-017 The block SHALL have port redirect_pc, output, 32, giving the correct next PC on mispredict.

Function
REQ-018 The block SHALL hold per-entry storage of valid (1b), tag (pc[31:INDEX_BITS+2]), target (32b) and 2-bit saturating counter: 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-019 The lookup SHALL be combinational: BTB index = pc_if[INDEX_BITS+1:2]; hit = valid && tag match; pred_taken_if = hit && counter[idx] MSB.
REQ-020 Lookup and update of the same entry in the same cycle SHALL return the pre-update (old) contents; no bypass.
REQ-021 On upd_valid with taken_ex=1, the counter at pht_idx_ex SHALL increment, saturating at 11.
REQ-022 On upd_valid with taken_ex=0, the counter at pht_idx_ex SHALL decrement, saturating at 00.
REQ-023 On upd_valid with taken_ex=1, the BTB entry at pc_ex index SHALL be written: valid=1, tag, target=target_ex; this replaces any alias.
REQ-024 On upd_valid with taken_ex=0, the BTB entry SHALL NOT be allocated or modified; only the counter changes.
REQ-025 When upd_valid=0, no state SHALL change.
REQ-026 mispredict SHALL be combinational = upd_valid && (taken_ex != pred_taken_ex || (taken_ex && target_ex != pred_target_ex)).
REQ-027 redirect_pc SHALL be target_ex if taken_ex, else pc_ex+4; the value is don't-care when mispredict=0.
REQ-028 All PC arithmetic SHALL be 32-bit modulo 2^32 (0xFFFFFFFC+4 = 0x00000000).

Reset
REQ-029 While reset_n=0, all valid bits SHALL be 0, all counters 01 (WNT), and GHR 0; this takes effect immediately, independent of clk.
REQ-030 During reset, outputs SHALL read pred_taken_if=0, pred_target_if=pc_if+4, mispredict=0 if upd_valid=0.
REQ-031 An update coinciding with reset assertion SHALL be discarded.

Configuration
REQ-032 When macro BP_GHR_EN is defined, a GHR_BITS global history register SHALL exist and pht_idx_if = pc_if[INDEX_BITS+1:2] XOR zero-extended GHR (gshare); on each upd_valid, GHR <= {GHR[GHR_BITS-2:0], taken_ex}.
REQ-033 When BP_GHR_EN is undefined, no GHR SHALL exist and pht_idx_if SHALL equal pc_if[INDEX_BITS+1:2] (bimodal); ports are unchanged.

Verification
REQ-034 After reset, pc_if=0x100 -> pred_taken_if=0, pred_target_if=0x104.
REQ-035 Update pc_ex=0x100 taken target 0x200 with pred_taken_ex=0 -> mispredict=1, redirect_pc=0x200; next cycle pc_if=0x100 -> pred_taken_if=1, target 0x200.
REQ-036 Five taken updates at 0x100 then two not-taken -> counter 11 then 01; pred_taken_if=0 after the second.
REQ-037 Alias 0x140 (same index, INDEX_BITS=4) taken to 0x300 after 0x100 entry -> pc_if=0x100 misses (pred_taken_if=0), pc_if=0x140 hits with 0x300.
REQ-038 Correct prediction taken, but target_ex=0x204 vs pred 0x200 -> mispredict=1, redirect_pc=0x204.
REQ-039 Assert reset_n low mid-sequence, asynchronously between edges -> pred_taken_if drops to 0 immediately; with BP_GHR_EN, GHR reads 0.
